// File: rtl/spi_frame_scheduler.sv
// Purpose: walks a frame buffer in raster order and hands one pixel at a time to spi_send_con.
// Latency: BRAM_LATENCY+1 fetch cycles, then WAIT_IDLE/SEND/ACK/DRAIN per pixel; VSYNC_CYCLES marker per frame.
// Backpressure: a trigger is issued only while spi_busy_in is low; unacknowledged triggers are retried.
module spi_frame_scheduler #(
  parameter int H_PIXELS     = 320,
  parameter int V_PIXELS     = 180,
  parameter int DATA_WIDTH   = 8,
  parameter int BRAM_LATENCY = 2,
  parameter int VSYNC_CYCLES = 16,
  parameter int ACK_TIMEOUT  = 4,
  parameter int ADDR_WIDTH   = $clog2(H_PIXELS*V_PIXELS)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  output logic [ADDR_WIDTH-1:0]       addr_out,
  input  logic [DATA_WIDTH-1:0]       bram_data_in,
  input  logic                        spi_busy_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        trigger_out,
  output logic [$clog2(H_PIXELS)-1:0] hcount_out,
  output logic [$clog2(V_PIXELS)-1:0] vcount_out,
  output logic                        spi_vsync_out,
  output logic                        frame_busy_out,
  output logic                        timeout_err_out
);

  localparam int HW = $clog2(H_PIXELS);
  localparam int VW = $clog2(V_PIXELS);

  // One shared cycle counter serves fetch latency, ack timeout and vsync length.
  localparam int CNT_MAX_A = (BRAM_LATENCY > ACK_TIMEOUT) ? BRAM_LATENCY : ACK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > VSYNC_CYCLES) ? CNT_MAX_A : VSYNC_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_PIXELS - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_PIXELS - 1);
  localparam logic [CW-1:0] LAT_DONE = CW'(BRAM_LATENCY);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_IDLE,
    S_SEND,
    S_ACK,
    S_DRAIN,
    S_VSYNC
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [HW-1:0]         r_h;
  logic [VW-1:0]         r_v;
  logic                  r_trigger;
  logic                  r_vsync;
  logic                  r_frame_busy;
  logic                  r_timeout_err;

  logic                  w_last_pixel;

  assign w_last_pixel = (r_h == H_LAST) && (r_v == V_LAST);

  // Frame sequencer: reset beats abort, abort beats every state transition.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_trigger     <= 1'b0;
      r_vsync       <= 1'b0;
      r_frame_busy  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (abort_in) begin
      // Sender keeps its current transfer; only our sequencing is dropped.
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_h          <= '0;
      r_v          <= '0;
      r_trigger    <= 1'b0;
      r_vsync      <= 1'b0;
      r_frame_busy <= 1'b0;
    end else begin
      r_trigger <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_state      <= S_FETCH;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_h          <= '0;
            r_v          <= '0;
            r_frame_busy <= 1'b1;
          end
        end

        S_FETCH: begin
          // Address is stable from the first FETCH cycle, data valid BRAM_LATENCY cycles later.
          if (r_cnt == LAT_DONE) begin
            r_data  <= bram_data_in;
            r_cnt   <= '0;
            r_state <= S_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_IDLE: begin
          if (!spi_busy_in) begin
            r_trigger <= 1'b1;
            r_state   <= S_SEND;
          end
        end

        S_SEND: begin
          // The SEND cycle itself counts as the first cycle of the ack window.
          r_cnt   <= CW'(1);
          r_state <= S_ACK;
        end

        S_ACK: begin
          if (spi_busy_in) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else if (r_cnt == ACK_LAST) begin
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DRAIN: begin
          if (!spi_busy_in) begin
            r_cnt <= '0;
            if (w_last_pixel) begin
              r_vsync <= 1'b1;
              r_state <= S_VSYNC;
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
              if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= r_v + VW'(1);
              end else begin
                r_h <= r_h + HW'(1);
              end
              r_state <= S_FETCH;
            end
          end
        end

        S_VSYNC: begin
          if (r_cnt == VS_LAST) begin
            r_vsync      <= 1'b0;
            r_frame_busy <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_h          <= '0;
            r_v          <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_vsync      <= 1'b0;
          r_frame_busy <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out        = r_addr;
  assign data_out        = r_data;
  assign trigger_out     = r_trigger;
  assign hcount_out      = r_h;
  assign vcount_out      = r_v;
  assign spi_vsync_out   = r_vsync;
  assign frame_busy_out  = r_frame_busy;
  assign timeout_err_out = r_timeout_err;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Bench for spi_frame_scheduler on a 4x2 frame with a BRAM model and an SPI sender model.
// Expected pixels are queued from raster-order arithmetic; a monitor pops one per trigger.
// Sender busy length and dropped acks are randomized in the final phase.
module tb_spi_frame_scheduler;

  localparam int H = 4;
  localparam int V = 2;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start_in = 1'b0;
  logic       abort_in = 1'b0;
  logic [2:0] addr_out;
  logic [7:0] bram_data_in;
  logic       spi_busy_in;
  logic [7:0] data_out;
  logic       trigger_out;
  logic [1:0] hcount_out;
  logic       vcount_out;
  logic       spi_vsync_out;
  logic       frame_busy_out;
  logic       timeout_err_out;

  spi_frame_scheduler #(
    .H_PIXELS(H), .V_PIXELS(V), .DATA_WIDTH(8), .BRAM_LATENCY(2),
    .VSYNC_CYCLES(16), .ACK_TIMEOUT(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
    .addr_out(addr_out), .bram_data_in(bram_data_in), .spi_busy_in(spi_busy_in),
    .data_out(data_out), .trigger_out(trigger_out), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .spi_vsync_out(spi_vsync_out),
    .frame_busy_out(frame_busy_out), .timeout_err_out(timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] h;
    logic       v;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_trig = 0;
  int ignore_at = -1;
  bit rand_drop = 1'b0;
  bit rand_len = 1'b0;
  int busy_len = 12;
  logic drop = 1'b0;
  logic force_busy = 1'b0;
  int snd_cnt = 0;
  logic [2:0] d1 = '0;
  logic [2:0] d2 = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Frame buffer: two-cycle read latency, contents = address + 0x10.
  always @(posedge clk_in) begin
    d1 <= addr_out;
    d2 <= d1;
  end
  assign bram_data_in = {5'b0, d2} + 8'h10;

  // Sender: busy for a burst starting one cycle after an accepted trigger.
  always @(posedge clk_in) begin
    if (trigger_out === 1'b1 && !drop)
      snd_cnt <= rand_len ? int'($urandom_range(1, 20)) : busy_len;
    else if (snd_cnt != 0)
      snd_cnt <= snd_cnt - 1;
  end
  assign spi_busy_in = (snd_cnt != 0) || force_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every trigger must match the head of the expected queue.
  always @(negedge clk_in) begin
    drop = 1'b0;
    if (trigger_out === 1'b1) begin
      n_trig++;
      chk("trigger_while_busy", {31'b0, spi_busy_in}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_trigger: got data 0x%0h with no pixel expected", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel", {19'b0, data_out, hcount_out, vcount_out}, {19'b0, mon_e});
        drop = (n_trig == ignore_at) || (rand_drop && ($urandom_range(0, 7) == 0));
        if (drop) exp_q.push_front(mon_e);
      end
    end
  end

  task automatic push_frame();
    for (int i = 0; i < H * V; i++)
      exp_q.push_back('{d: 8'(i + 16), h: 2'(i % H), v: 1'(i / H)});
  endtask

  task automatic pulse_start();
    @(posedge clk_in); #1 start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk_in); #1;
  endtask

  task automatic wait_trig(input int n);
    int k;
    k = 0;
    while (n_trig < n && k < 3000) begin settle(); k++; end
    if (n_trig < n) begin
      checks++; failures++;
      $display("FAIL wait_trig: got %0d triggers expected %0d", n_trig, n);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_addr"}, {29'b0, addr_out}, 0);
    chk({nm, "_data"}, {24'b0, data_out}, 0);
    chk({nm, "_trigger"}, {31'b0, trigger_out}, 0);
    chk({nm, "_hcount"}, {30'b0, hcount_out}, 0);
    chk({nm, "_vcount"}, {31'b0, vcount_out}, 0);
    chk({nm, "_vsync"}, {31'b0, spi_vsync_out}, 0);
    chk({nm, "_frame_busy"}, {31'b0, frame_busy_out}, 0);
    chk({nm, "_timeout_err"}, {31'b0, timeout_err_out}, 0);
  endtask

  // Waits for the end-of-frame marker, measures it and checks the return to idle.
  task automatic run_to_end(input string nm);
    int k;
    int hi;
    k = 0;
    while (spi_vsync_out !== 1'b1 && k < 5000) begin settle(); k++; end
    hi = 0;
    while (spi_vsync_out === 1'b1 && hi < 100) begin hi++; settle(); end
    chk({nm, "_vsync_len"}, hi, 16);
    chk({nm, "_idle_busy"}, {31'b0, frame_busy_out}, 0);
    chk({nm, "_idle_cnt"}, {28'b0, addr_out, hcount_out, vcount_out}, 0);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t0;
    int hi;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    settle();
    chk_all_zero("reset");

    // Full frame with a fixed 12-cycle sender.
    base = n_trig;
    push_frame();
    pulse_start();
    run_to_end("full");
    chk("full_trig_count", n_trig - base, 8);

    // Sender busy at start: nothing leaves until it drops.
    base = n_trig;
    push_frame();
    @(posedge clk_in); #1 force_busy = 1'b1;
    pulse_start();
    repeat (50) @(posedge clk_in);
    #1;
    chk("busy_hold_no_trig", n_trig - base, 0);
    force_busy = 1'b0;
    @(negedge clk_in);
    chk("busy_release_not_yet", {31'b0, trigger_out}, 0);
    @(negedge clk_in);
    chk("busy_release_trig", {31'b0, trigger_out}, 1);
    run_to_end("busy");
    chk("busy_trig_count", n_trig - base, 8);

    // Third trigger ignored by the sender.
    chk("err_before", {31'b0, timeout_err_out}, 0);
    base = n_trig;
    ignore_at = base + 3;
    push_frame();
    pulse_start();
    wait_trig(base + 3);
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (timeout_err_out === 1'b1) break;
    end
    chk("err_rise_delay", cyc - t0, 4);
    run_to_end("noack");
    chk("noack_trig_count", n_trig - base, 9);
    chk("err_sticky", {31'b0, timeout_err_out}, 1);
    ignore_at = -1;

    // Abort during the fifth pixel's drain, with a long sender burst.
    busy_len = 30;
    base = n_trig;
    push_frame();
    pulse_start();
    wait_trig(base + 5);
    repeat (5) @(posedge clk_in);
    #1 abort_in = 1'b1;
    @(posedge clk_in); #1 abort_in = 1'b0;
    settle();
    chk("abort_busy", {31'b0, frame_busy_out}, 0);
    chk("abort_cnt", {28'b0, addr_out, hcount_out, vcount_out}, 0);
    chk("abort_trig_vsync", {30'b0, trigger_out, spi_vsync_out}, 0);
    chk("abort_remaining", exp_q.size(), 3);
    exp_q.delete();
    hi = 0;
    repeat (5) begin settle(); if (spi_vsync_out === 1'b1) hi++; end
    chk("abort_no_vsync", hi, 0);
    base = n_trig;
    push_frame();
    pulse_start();
    run_to_end("after_abort");
    chk("after_abort_trig_count", n_trig - base, 8);
    busy_len = 12;

    // Start mid-frame is ignored.
    base = n_trig;
    push_frame();
    pulse_start();
    wait_trig(base + 3);
    pulse_start();
    run_to_end("midstart");
    chk("midstart_trig_count", n_trig - base, 8);

    // Reset mid-frame clears everything including the sticky error.
    base = n_trig;
    push_frame();
    pulse_start();
    wait_trig(base + 2);
    repeat (4) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    settle();
    chk_all_zero("midreset");
    chk("midreset_remaining", exp_q.size(), 6);
    exp_q.delete();
    repeat (20) @(posedge clk_in);

    // Randomized sender burst lengths and dropped acks.
    rand_len = 1'b1;
    rand_drop = 1'b1;
    for (int f = 0; f < 4; f++) begin
      push_frame();
      repeat ($urandom_range(0, 10)) @(posedge clk_in);
      pulse_start();
      run_to_end("random");
    end
    rand_drop = 1'b0;
    rand_len = 1'b0;

    repeat (5) @(posedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
